vga_timing_gen: RTL and testbench
=================================

// Module: vga_timing_gen
// PURPOSE
//  Parametrised VGA raster timing generator with an on-chip pixel-rate enable and a lookahead fetch pointer.
//  Replaces the fixed 640x480 controller and the free-running divide-by-2 pixel clock in the top level.
//  The whole system stays on one clock domain (clk). Downstream logic qualifies on pix_en.
//  fetch_x/fetch_y lead the displayed pixel so BRAM port-B reads land on time.
// PARAMETERS
//  CLK_DIV    2    clk cycles per pixel (>=1); pix_en asserts once every CLK_DIV cycles
//  H_ACTIVE   640  visible pixels per line
//  H_FP       16   horizontal front porch (pixels)
//  H_SYNC     96   horizontal sync width (pixels)
//  H_BP       48   horizontal back porch (pixels)
//  V_ACTIVE   480  visible lines
//  V_FP       10   vertical front porch (lines)
//  V_SYNC     2    vertical sync width (lines)
//  V_BP       33   vertical back porch (lines)
//  HS_POL     0    hs level while in sync (0 = active-low)
//  VS_POL     0    vs level while in sync
//  LOOKAHEAD  2    pixels by which fetch_* lead hcount/vcount; 0 <= LOOKAHEAD < H_TOTAL
//  CW         10   counter width; 2**CW must be >= max(H_TOTAL, V_TOTAL)
// PORTS
//  clk          in   1   system clock
//  rst          in   1   asynchronous reset, active-low
//  pix_en       out  1   one-clk pixel strobe
//  hcount       out  CW  current pixel column, 0..H_TOTAL-1
//  vcount       out  CW  current line, 0..V_TOTAL-1
//  hs           out  1   horizontal sync
//  vs           out  1   vertical sync
//  bright       out  1   1 when hcount<H_ACTIVE and vcount<V_ACTIVE
//  line_start   out  1   1 for the pix_en cycle in which hcount becomes 0
//  frame_start  out  1   1 for the pix_en cycle in which (hcount,vcount) becomes (0,0)
//  fetch_x      out  CW  column LOOKAHEAD pixels ahead (mod H_TOTAL)
//  fetch_y      out  CW  line of that position; carries into the next line and wraps at the frame end
//  fetch_valid  out  1   fetch position lies in the active area
//  frame_count  out  16  frames started (macro-dependent)
// BEHAVIOUR
//  - Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise.
//  - Divider div counts 0..CLK_DIV-1. pix_en is a registered 1 while div==CLK_DIV-1. With CLK_DIV=1, pix_en is constantly 1 after reset.
//  - Reset (rst=0, async) values:
//    - div=0, pix_en=0
//    - hcount=H_TOTAL-1, vcount=V_TOTAL-1 (last pixel of the frame)
//    - bright=0, hs=~HS_POL, vs=~VS_POL
//    - line_start=0, frame_start=0, frame_count=0
//    - fetch_x=LOOKAHEAD-1 (or H_TOTAL-1 if LOOKAHEAD=0); fetch_y=0 (or V_TOTAL-1 if LOOKAHEAD=0); fetch_valid = decode of that position
//  - First pix_en after rst deasserts moves to (0,0): bright=1, line_start=frame_start=1. No pixel is skipped.
//  - Advance on pix_en only:
//    - hcount==H_TOTAL-1 -> hcount=0 and vcount steps (V_TOTAL-1 wraps to 0); otherwise hcount+1.
//    - The fetch pair advances identically and independently.
//  - All outputs are registered, updated on the same edge as the counters, and always consistent with the hcount/vcount held that cycle (zero decode latency).
//  - hs = HS_POL iff H_ACTIVE+H_FP <= hcount < H_ACTIVE+H_FP+H_SYNC.
//  - vs = VS_POL iff V_ACTIVE+V_FP <= vcount < V_ACTIVE+V_FP+V_SYNC. vs changes only together with an hcount wrap.
//  - line_start and frame_start are 1 only during a pix_en cycle; otherwise 0. frame_start implies line_start.
//  - Between strobes every output holds its value.
//  - Reset asserted mid-frame returns to the reset state immediately. No partial sync pulse is extended.
// CONFIGURATION
//  VGA_TIMING_FRAME_CNT_EN defined:
//    frame_count increments by 1 on every frame_start and wraps 16'hFFFF -> 0.
//  Not defined:
//    frame_count is tied to 16'h0000 and no counter logic is synthesised. All other behaviour is identical.
// TESTING
//  - Reset, then release with defaults: pix_en every 2nd clk; first strobe gives hcount=0, vcount=0, bright=1, frame_start=1.
//  - Run one line: hs=0 exactly for hcount 656..751; bright=0 from hcount 640; line_start period = 1600 clk.
//  - Run full frames: vs=0 for vcount 490..491; frame_start period = 840000 clk; with macro, frame_count 0->1->2.
//  - LOOKAHEAD=2: at hcount=798, vcount=10 -> fetch=(0,11); at (799,524) -> fetch=(1,0), fetch_valid=1.
//  - Drop rst at hcount=700 (inside hsync) -> hs=1, bright=0, hcount=799, vcount=524 same cycle; they hold until release.
//  - CLK_DIV=1, HS_POL=1, 4x2 active, 1/1/1 porches (H_TOTAL=7, V_TOTAL=5): pix_en=1 every clk; hs=1 only at hcount 5; frame period = 35 clk.

Source files
------------

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA raster timing generator on a single clock.
// A clock-enable divider produces pix_en; the raster counters, sync/blank
// decodes and a lookahead fetch pointer all advance together on that strobe.
// Every output is registered and decoded from the position being loaded,
// so it always matches the hcount/vcount held in the same cycle.
// Optional feature: define VGA_TIMING_FRAME_CNT_EN to build the 16-bit frame
// counter; without it frame_count is tied to zero.
module vga_timing_gen #(
  parameter int   CLK_DIV   = 2,
  parameter int   H_ACTIVE  = 640,
  parameter int   H_FP      = 16,
  parameter int   H_SYNC    = 96,
  parameter int   H_BP      = 48,
  parameter int   V_ACTIVE  = 480,
  parameter int   V_FP      = 10,
  parameter int   V_SYNC    = 2,
  parameter int   V_BP      = 33,
  parameter logic HS_POL    = 1'b0,
  parameter logic VS_POL    = 1'b0,
  parameter int   LOOKAHEAD = 2,
  parameter int   CW        = 10
) (
  input  logic          clk,
  input  logic          rst,
  output logic          pix_en,
  output logic [CW-1:0] hcount,
  output logic [CW-1:0] vcount,
  output logic          hs,
  output logic          vs,
  output logic          bright,
  output logic          line_start,
  output logic          frame_start,
  output logic [CW-1:0] fetch_x,
  output logic [CW-1:0] fetch_y,
  output logic          fetch_valid,
  output logic [15:0]   frame_count
);

  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int H_LAST   = H_TOTAL - 1;
  localparam int V_LAST   = V_TOTAL - 1;
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_STOP  = HS_START + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_STOP  = VS_START + V_SYNC;

  // Divider width; a divide-by-1 still keeps a 1-bit register that stays 0.
  localparam int            DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  // Reset parks the raster on the last pixel of the frame so the first strobe
  // lands on (0,0); the fetch pointer sits LOOKAHEAD pixels past that point.
  localparam int   FX_RST = (LOOKAHEAD == 0) ? H_TOTAL - 1 : LOOKAHEAD - 1;
  localparam int   FY_RST = (LOOKAHEAD == 0) ? V_TOTAL - 1 : 0;
  localparam logic FV_RST = (FX_RST < H_ACTIVE) && (FY_RST < V_ACTIVE);

  // Zero-extend a counter to 32 bits so it compares cleanly with int bounds.
  function automatic logic [31:0] ext(input logic [CW-1:0] v);
    return {{(32-CW){1'b0}}, v};
  endfunction

  // True when v lies in the half-open window [lo, hi).
  function automatic logic in_win(input logic [CW-1:0] v, input int lo, input int hi);
    return (ext(v) >= $unsigned(lo)) && (ext(v) < $unsigned(hi));
  endfunction

  logic [DW-1:0] div_reg, div_next;
  logic          tick;
  logic          pix_en_reg;
  logic [CW-1:0] hcount_reg, vcount_reg, hcount_next, vcount_next;
  logic [CW-1:0] fetch_x_reg, fetch_y_reg, fetch_x_next, fetch_y_next;
  logic          h_wrap, fx_wrap;
  logic          hs_reg, vs_reg, bright_reg, fetch_valid_reg;
  logic          hs_next, vs_next, bright_next, fetch_valid_next;
  logic          line_start_reg, frame_start_reg;
  logic          line_start_next, frame_start_next;

  // Divider: tick marks the edge that loads pix_en=1 and advances the raster.
  always_comb begin
    div_next = (div_reg == DIV_LAST) ? '0 : div_reg + DW'(1);
    tick     = (div_next == DIV_LAST);
  end

  // Next raster and fetch positions plus the decodes of those positions.
  always_comb begin
    h_wrap      = (ext(hcount_reg) == $unsigned(H_LAST));
    hcount_next = h_wrap ? '0 : hcount_reg + CW'(1);
    vcount_next = vcount_reg;
    if (h_wrap) begin
      vcount_next = (ext(vcount_reg) == $unsigned(V_LAST)) ? '0 : vcount_reg + CW'(1);
    end

    fx_wrap      = (ext(fetch_x_reg) == $unsigned(H_LAST));
    fetch_x_next = fx_wrap ? '0 : fetch_x_reg + CW'(1);
    fetch_y_next = fetch_y_reg;
    if (fx_wrap) begin
      fetch_y_next = (ext(fetch_y_reg) == $unsigned(V_LAST)) ? '0 : fetch_y_reg + CW'(1);
    end

    hs_next          = in_win(hcount_next, HS_START, HS_STOP) ? HS_POL : ~HS_POL;
    vs_next          = in_win(vcount_next, VS_START, VS_STOP) ? VS_POL : ~VS_POL;
    bright_next      = in_win(hcount_next, 0, H_ACTIVE) && in_win(vcount_next, 0, V_ACTIVE);
    fetch_valid_next = in_win(fetch_x_next, 0, H_ACTIVE) && in_win(fetch_y_next, 0, V_ACTIVE);
    line_start_next  = (hcount_next == '0);
    frame_start_next = (hcount_next == '0) && (vcount_next == '0);
  end

  // Divider and pixel strobe registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_reg    <= '0;
      pix_en_reg <= 1'b0;
    end else begin
      div_reg    <= div_next;
      pix_en_reg <= tick;
    end
  end

  // Raster position and its decodes; held between strobes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hcount_reg <= CW'(H_TOTAL - 1);
      vcount_reg <= CW'(V_TOTAL - 1);
      hs_reg     <= ~HS_POL;
      vs_reg     <= ~VS_POL;
      bright_reg <= 1'b0;
    end else if (tick) begin
      hcount_reg <= hcount_next;
      vcount_reg <= vcount_next;
      hs_reg     <= hs_next;
      vs_reg     <= vs_next;
      bright_reg <= bright_next;
    end
  end

  // Lookahead fetch pointer; walks the frame independently of the raster.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_x_reg     <= CW'(FX_RST);
      fetch_y_reg     <= CW'(FY_RST);
      fetch_valid_reg <= FV_RST;
    end else if (tick) begin
      fetch_x_reg     <= fetch_x_next;
      fetch_y_reg     <= fetch_y_next;
      fetch_valid_reg <= fetch_valid_next;
    end
  end

  // Line/frame markers live only for the strobe cycle that reaches them.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      line_start_reg  <= 1'b0;
      frame_start_reg <= 1'b0;
    end else begin
      line_start_reg  <= tick && line_start_next;
      frame_start_reg <= tick && frame_start_next;
    end
  end

`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [15:0] frame_cnt_reg;

  // Frames started since reset; wraps naturally at 16 bits.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frame_cnt_reg <= 16'h0000;
    end else if (tick && frame_start_next) begin
      frame_cnt_reg <= frame_cnt_reg + 16'd1;
    end
  end

  assign frame_count = frame_cnt_reg;
`else
  assign frame_count = 16'h0000;
`endif

  assign pix_en      = pix_en_reg;
  assign hcount      = hcount_reg;
  assign vcount      = vcount_reg;
  assign hs          = hs_reg;
  assign vs          = vs_reg;
  assign bright      = bright_reg;
  assign line_start  = line_start_reg;
  assign frame_start = frame_start_reg;
  assign fetch_x     = fetch_x_reg;
  assign fetch_y     = fetch_y_reg;
  assign fetch_valid = fetch_valid_reg;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: three configurations share one clock and reset.
// Expected outputs come from an arithmetic model of clk edges since reset
// release: strobe count -> linear pixel index -> (x,y) and window decodes.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int div, ha, hfp, hsy, hbp, va, vfp, vsy, vbp, la, hpol, vpol;
  } cfg_t;

  typedef struct {
    int pe, h, v, hs, vs, br, ls, fs, fx, fy, fv, fc;
  } exp_t;

  cfg_t cfg [3];
  exp_t q0[$], q1[$], q2[$];
  int   total = 0;
  int   bad   = 0;

  // Instance 0: default 640x480 timing.
  logic       pe0, hs0, vs0, br0, ls0, fs0, fv0;
  logic [9:0] hc0, vc0, fx0, fy0;
  logic [15:0] fc0;
  vga_timing_gen u0 (
    .clk(clk), .rst(rst), .pix_en(pe0), .hcount(hc0), .vcount(vc0), .hs(hs0), .vs(vs0),
    .bright(br0), .line_start(ls0), .frame_start(fs0), .fetch_x(fx0), .fetch_y(fy0),
    .fetch_valid(fv0), .frame_count(fc0));

  // Instance 1: tiny raster, divide-by-1, active-high hsync.
  logic       pe1, hs1, vs1, br1, ls1, fs1, fv1;
  logic [2:0] hc1, vc1, fx1, fy1;
  logic [15:0] fc1;
  vga_timing_gen #(
    .CLK_DIV(1), .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
    .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1), .HS_POL(1'b1), .VS_POL(1'b0),
    .LOOKAHEAD(2), .CW(3)
  ) u1 (
    .clk(clk), .rst(rst), .pix_en(pe1), .hcount(hc1), .vcount(vc1), .hs(hs1), .vs(vs1),
    .bright(br1), .line_start(ls1), .frame_start(fs1), .fetch_x(fx1), .fetch_y(fy1),
    .fetch_valid(fv1), .frame_count(fc1));

  // Instance 2: divide-by-3, no lookahead, active-high vsync.
  logic       pe2, hs2, vs2, br2, ls2, fs2, fv2;
  logic [3:0] hc2, vc2, fx2, fy2;
  logic [15:0] fc2;
  vga_timing_gen #(
    .CLK_DIV(3), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .HS_POL(1'b0), .VS_POL(1'b1),
    .LOOKAHEAD(0), .CW(4)
  ) u2 (
    .clk(clk), .rst(rst), .pix_en(pe2), .hcount(hc2), .vcount(vc2), .hs(hs2), .vs(vs2),
    .bright(br2), .line_start(ls2), .frame_start(fs2), .fetch_x(fx2), .fetch_y(fy2),
    .fetch_valid(fv2), .frame_count(fc2));

  // Expected outputs after c clk edges with rst high (c=0: held in reset).
  function automatic exp_t model(cfg_t k, longint c);
    exp_t   e;
    longint ht, vt, tot, strobes, idx, fidx;
    ht  = k.ha + k.hfp + k.hsy + k.hbp;
    vt  = k.va + k.vfp + k.vsy + k.vbp;
    tot = ht * vt;
    if (c == 0) begin
      e.pe    = 0;
      strobes = 0;
    end else begin
      // Edge n leaves pix_en high when (n+1) is a multiple of div.
      e.pe    = (((c + 1) % k.div) == 0) ? 1 : 0;
      strobes = (c + 1) / k.div - 1 / k.div;
    end
    idx  = (strobes + tot - 1) % tot;
    fidx = (idx + k.la) % tot;
    e.h  = int'(idx % ht);
    e.v  = int'(idx / ht);
    e.fx = int'(fidx % ht);
    e.fy = int'(fidx / ht);
    e.hs = (e.h >= k.ha + k.hfp && e.h < k.ha + k.hfp + k.hsy) ? k.hpol : 1 - k.hpol;
    e.vs = (e.v >= k.va + k.vfp && e.v < k.va + k.vfp + k.vsy) ? k.vpol : 1 - k.vpol;
    e.br = (e.h < k.ha && e.v < k.va) ? 1 : 0;
    e.fv = (e.fx < k.ha && e.fy < k.va) ? 1 : 0;
    e.ls = (e.pe == 1 && e.h == 0) ? 1 : 0;
    e.fs = (e.pe == 1 && idx == 0) ? 1 : 0;
`ifdef VGA_TIMING_FRAME_CNT_EN
    e.fc = int'(((strobes + tot - 1) / tot) % 65536);
`else
    e.fc = 0;
`endif
    return e;
  endfunction

  task automatic chk(input string name, input int act, input int want);
    total++;
    if (act != want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d t=%0t", name, act, want, $time);
    end
  endtask

  task automatic chk_all(input string tag, input exp_t a, input exp_t e);
    chk({tag, ".pix_en"}, a.pe, e.pe);
    chk({tag, ".hcount"}, a.h, e.h);
    chk({tag, ".vcount"}, a.v, e.v);
    chk({tag, ".hs"}, a.hs, e.hs);
    chk({tag, ".vs"}, a.vs, e.vs);
    chk({tag, ".bright"}, a.br, e.br);
    chk({tag, ".line_start"}, a.ls, e.ls);
    chk({tag, ".frame_start"}, a.fs, e.fs);
    chk({tag, ".fetch_x"}, a.fx, e.fx);
    chk({tag, ".fetch_y"}, a.fy, e.fy);
    chk({tag, ".fetch_valid"}, a.fv, e.fv);
    chk({tag, ".frame_count"}, a.fc, e.fc);
  endtask

  // Monitor: one transaction per clk, sampled on the falling edge.
  initial begin
    exp_t a, e;
    forever begin
      @(negedge clk);
      if (q0.size() == 0 || q1.size() == 0 || q2.size() == 0) begin
        total++;
        bad++;
        $display("FAIL scoreboard_empty t=%0t", $time);
      end else begin
        a = '{int'(pe0), int'(hc0), int'(vc0), int'(hs0), int'(vs0), int'(br0), int'(ls0),
              int'(fs0), int'(fx0), int'(fy0), int'(fv0), int'(fc0)};
        e = q0.pop_front();
        chk_all("u0", a, e);
        a = '{int'(pe1), int'(hc1), int'(vc1), int'(hs1), int'(vs1), int'(br1), int'(ls1),
              int'(fs1), int'(fx1), int'(fy1), int'(fv1), int'(fc1)};
        e = q1.pop_front();
        chk_all("u1", a, e);
        a = '{int'(pe2), int'(hc2), int'(vc2), int'(hs2), int'(vs2), int'(br2), int'(ls2),
              int'(fs2), int'(fx2), int'(fy2), int'(fv2), int'(fc2)};
        e = q2.pop_front();
        chk_all("u2", a, e);
      end
    end
  end

  longint cnt = 0;

  task automatic push_all();
    q0.push_back(model(cfg[0], cnt));
    q1.push_back(model(cfg[1], cnt));
    q2.push_back(model(cfg[2], cnt));
  endtask

  // One clk: account for the edge just taken, then drive rst for this cycle.
  task automatic step(input logic new_rst);
    @(posedge clk);
    #2;
    if (rst) cnt++;
    rst = new_rst;
    if (!new_rst) cnt = 0;
    push_all();
  endtask

  // Stimulus: reset, long run, reset inside hsync, then random reset pulses.
  initial begin
    int  rlen;
    bit  hit;
    cfg[0] = '{2, 640, 16, 96, 48, 480, 10, 2, 33, 2, 0, 0};
    cfg[1] = '{1, 4, 1, 1, 1, 2, 1, 1, 1, 2, 1, 0};
    cfg[2] = '{3, 8, 2, 3, 1, 4, 1, 2, 1, 0, 0, 1};
    rst = 1'b0;

    repeat (3) step(1'b0);
    repeat (20000) step(1'b1);

    hit = 0;
    for (int k = 0; k < 4000 && !hit; k++) begin
      @(posedge clk);
      #2;
      if (rst) cnt++;
      if (model(cfg[0], cnt).h == 700) begin
        hit = 1;
        rst = 1'b0;
        cnt = 0;
      end
      push_all();
    end
    total++;
    if (!hit) begin
      bad++;
      $display("FAIL reach_hcount_700 got=0 want=1");
    end
    repeat (3) step(1'b0);

    rlen = 0;
    repeat (30000) begin
      if (rlen == 0 && $urandom_range(0, 2999) == 0) rlen = int'($urandom_range(1, 4));
      if (rlen > 0) begin
        step(1'b0);
        rlen--;
      end else begin
        step(1'b1);
      end
    end

    @(negedge clk);
    #1;
    total++;
    if (q0.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_leftover got=%0d want=0", q0.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
